// File: rtl/elevator_dispatcher_if.sv
// Signal bundle between the hall panel / car controllers (master) and the
// group dispatcher (slave).
interface elevator_dispatcher_if #(
  parameter int NUM_CARS   = 2,
  parameter int NUM_FLOORS = 5,
  parameter int FLOOR_W    = 3
);
  logic [NUM_FLOORS-1:0]          hall_up;
  logic [NUM_FLOORS-1:0]          hall_dn;
  logic [NUM_CARS*NUM_FLOORS-1:0] car_buttons;
  logic [NUM_CARS*FLOOR_W-1:0]    car_floor;
  logic [NUM_CARS-1:0]            car_up;
  logic [NUM_CARS-1:0]            car_down;
  logic [NUM_CARS-1:0]            car_served;
  logic [NUM_CARS*NUM_FLOORS-1:0] car_requests;
  logic [NUM_FLOORS-1:0]          up_pending;
  logic [NUM_FLOORS-1:0]          dn_pending;
  logic                           assign_valid;
  logic [2:0]                     assign_car;
  logic [FLOOR_W-1:0]             assign_floor;
  logic                           assign_dir;

  modport master (
    output hall_up, hall_dn, car_buttons, car_floor, car_up, car_down, car_served,
    input  car_requests, up_pending, dn_pending, assign_valid, assign_car,
           assign_floor, assign_dir
  );

  modport slave (
    input  hall_up, hall_dn, car_buttons, car_floor, car_up, car_down, car_served,
    output car_requests, up_pending, dn_pending, assign_valid, assign_car,
           assign_floor, assign_dir
  );
endinterface

// File: rtl/elevator_dispatcher.sv
// Group dispatcher: latches hall calls, assigns each to the cheapest car by a
// scanning pointer, and holds the assignment until the owning car serves it.
module elevator_dispatcher #(
  parameter int NUM_CARS   = 2,
  parameter int NUM_FLOORS = 5,
  parameter int FLOOR_W    = 3
) (
  input logic                  clk,
  input logic                  reset,
  elevator_dispatcher_if.slave bus
);
  localparam int NS = 2 * NUM_FLOORS;
  localparam int PW = $clog2(NS);
  localparam int CW = FLOOR_W + 2;
  localparam logic [CW-1:0] TOP = CW'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, SCAN} state_e;

  state_e                         state_q, state_d;
  logic [NS-1:0]                  pend_q, pend_d;
  logic [NS-1:0]                  asg_q, asg_d;
  logic [2:0]                     owner_q [NS];
  logic [2:0]                     owner_d [NS];
  logic [PW-1:0]                  ptr_q, ptr_d;
  logic [NUM_CARS*NUM_FLOORS-1:0] req_q, req_d;
  logic                           av_q, av_d;
  logic [2:0]                     acar_q, acar_d;
  logic [FLOOR_W-1:0]             afl_q, afl_d;
  logic                           adir_q, adir_d;

  logic [NS-1:0]       press;
  logic [NS-1:0]       clr;
  logic [FLOOR_W-1:0]  cf      [NUM_CARS];
  logic [CW-1:0]       cost    [NUM_CARS];
  logic [NUM_CARS-1:0] up_only;
  logic [NUM_CARS-1:0] dn_only;
  logic                scan_up;
  logic [FLOOR_W-1:0]  scan_fl;
  logic [2:0]          best_car;
  logic [CW-1:0]       best_cost;

  // Direction-aware distance; a car committed away from the call pays for the
  // turnaround at the end of its travel.
  function automatic logic [CW-1:0] cost_f(input logic [FLOOR_W-1:0] cf_in,
                                           input logic [FLOOR_W-1:0] d_in,
                                           input logic up, input logic dn);
    logic [CW-1:0] c;
    logic [CW-1:0] d;
    c = CW'(cf_in);
    d = CW'(d_in);
    if (up && !dn)      return (d >= c) ? d - c : (TOP - c) + (TOP - d);
    else if (dn && !up) return (d <= c) ? c - d : c + d;
    else                return (d >= c) ? d - c : c - d;
  endfunction

  assign press   = {bus.hall_dn & DN_MASK, bus.hall_up & UP_MASK};
  assign scan_up = ptr_q < PW'(NUM_FLOORS);
  assign scan_fl = scan_up ? FLOOR_W'(ptr_q) : FLOOR_W'(ptr_q - PW'(NUM_FLOORS));

  for (genvar gi = 0; gi < NUM_CARS; gi++) begin : g_car
    assign cf[gi]      = bus.car_floor[gi*FLOOR_W +: FLOOR_W];
    assign up_only[gi] = bus.car_up[gi] & ~bus.car_down[gi];
    assign dn_only[gi] = bus.car_down[gi] & ~bus.car_up[gi];
    assign cost[gi]    = cost_f(cf[gi], scan_fl, bus.car_up[gi], bus.car_down[gi]);
    for (genvar gj = 0; gj < NUM_FLOORS; gj++) begin : g_fl
      assign req_d[gi*NUM_FLOORS + gj] = bus.car_buttons[gi*NUM_FLOORS + gj]
          | (pend_q[gj] & asg_q[gj] & (owner_q[gj] == 3'(gi)))
          | (pend_q[gj+NUM_FLOORS] & asg_q[gj+NUM_FLOORS]
             & (owner_q[gj+NUM_FLOORS] == 3'(gi)));
    end
  end

  // A slot clears when its owner opens doors at the slot's floor while not
  // committed against the slot's direction.
  for (genvar gi = 0; gi < NS; gi++) begin : g_slot
    localparam int  SLOT_FL = (gi < NUM_FLOORS) ? gi : gi - NUM_FLOORS;
    localparam bit  IS_UP   = (gi < NUM_FLOORS);
    logic hit;
    always_comb begin
      hit = 1'b0;
      for (int c = 0; c < NUM_CARS; c++) begin
        if (owner_q[gi] == 3'(c) && bus.car_served[c] && cf[c] == FLOOR_W'(SLOT_FL)
            && (IS_UP ? !dn_only[c] : !up_only[c]))
          hit = 1'b1;
      end
    end
    assign clr[gi] = hit & pend_q[gi] & asg_q[gi];
  end

  always_comb begin
    best_car  = 3'd0;
    best_cost = cost[0];
    for (int c = 1; c < NUM_CARS; c++) begin
      if (cost[c] < best_cost) begin
        best_car  = 3'(c);
        best_cost = cost[c];
      end
    end
  end

  always_comb begin
    pend_d  = (pend_q | press) & ~clr;
    asg_d   = asg_q & ~clr;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    av_d    = 1'b0;
    acar_d  = acar_q;
    afl_d   = afl_q;
    adir_d  = adir_q;
    for (int s = 0; s < NS; s++) begin
      if (clr[s]) owner_d[s] = 3'd0;
    end
    if (state_q == SCAN) begin
      ptr_d = (ptr_q == PW'(NS - 1)) ? '0 : ptr_q + 1'b1;
      if (pend_q[ptr_q] && !asg_q[ptr_q] && !clr[ptr_q]) begin
        asg_d[ptr_q]   = 1'b1;
        owner_d[ptr_q] = best_car;
        av_d           = 1'b1;
        acar_d         = best_car;
        afl_d          = scan_fl;
        adir_d         = scan_up;
      end
    end
    state_d = (|(pend_d & ~asg_d)) ? SCAN : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      asg_q   <= '0;
      ptr_q   <= '0;
      req_q   <= '0;
      av_q    <= 1'b0;
      acar_q  <= '0;
      afl_q   <= '0;
      adir_q  <= 1'b0;
      for (int s = 0; s < NS; s++) owner_q[s] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      asg_q   <= asg_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      av_q    <= av_d;
      acar_q  <= acar_d;
      afl_q   <= afl_d;
      adir_q  <= adir_d;
    end
  end

  assign bus.car_requests = req_q;
  assign bus.up_pending   = pend_q[NUM_FLOORS-1:0];
  assign bus.dn_pending   = pend_q[NS-1:NUM_FLOORS];
  assign bus.assign_valid = av_q;
  assign bus.assign_car   = acar_q;
  assign bus.assign_floor = afl_q;
  assign bus.assign_dir   = adir_q;
endmodule

// File: tb/tb_elevator_dispatcher.sv
// Scoreboard bench for elevator_dispatcher: directed calls push expected
// assignments; a monitor pops and compares on every assign_valid pulse.
module tb_elevator_dispatcher;
  localparam int NC = 2;
  localparam int NF = 5;
  localparam int FW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  elevator_dispatcher_if #(.NUM_CARS(NC), .NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_dispatcher #(.NUM_CARS(NC), .NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    car;
    logic [FW-1:0] fl;
    logic          dir;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic void chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h @%0t", nm, act, req, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_cars(input int f0, input int f1, input logic [1:0] up, input logic [1:0] dn);
    bus.car_floor = {FW'(f1), FW'(f0)};
    bus.car_up    = up;
    bus.car_down  = dn;
  endtask

  task automatic push(input int car, input int fl, input int dir);
    exp_t e;
    e.car = 3'(car);
    e.fl  = FW'(fl);
    e.dir = dir[0];
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    chk("assign_timeout", sb.size(), 0);
    sb.delete();
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.assign_valid === 1'b1) begin
      $display("assign car=%0d floor=%0d dir=%0d @%0t",
               bus.assign_car, bus.assign_floor, bus.assign_dir, $time);
      if (sb.size() == 0) begin
        chk("unexpected_assign", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("assign_car", int'(bus.assign_car), int'(e.car));
        chk("assign_floor", int'(bus.assign_floor), int'(e.fl));
        chk("assign_dir", int'(bus.assign_dir), int'(e.dir));
      end
    end
  end

  initial begin
    bus.hall_up     = '0;
    bus.hall_dn     = '0;
    bus.car_buttons = '0;
    bus.car_served  = '0;
    set_cars(0, 4, 2'b00, 2'b00);
    bus.hall_up = 5'b00110;  // pressed during reset, must not latch
    do_reset();
    bus.hall_up = '0;

    // Reset state and quiet idle period
    chk("rst_requests", int'(bus.car_requests), 0);
    chk("rst_up_pending", int'(bus.up_pending), 0);
    chk("rst_dn_pending", int'(bus.dn_pending), 0);
    chk("rst_assign", int'({bus.assign_valid, bus.assign_car, bus.assign_floor, bus.assign_dir}), 0);
    repeat (20) step();
    chk("idle_up_pending", int'(bus.up_pending), 0);
    chk("idle_dn_pending", int'(bus.dn_pending), 0);

    // In-car button passes straight to the request vector
    bus.car_buttons = 10'h020;
    step();
    bus.car_buttons = '0;
    chk("btn_request", int'(bus.car_requests), 'h020);
    step();
    chk("btn_request_clear", int'(bus.car_requests), 0);

    // Idle cars at 0 and 4, up call at floor 1 goes to car0
    bus.hall_up = 5'b00010;
    push(0, 1, 1);
    step();
    bus.hall_up = '0;
    chk("up1_pending", int'(bus.up_pending), 'b00010);
    wait_sb(10);
    step();
    chk("up1_request", int'(bus.car_requests), 'h002);
    set_cars(1, 4, 2'b00, 2'b00);
    bus.car_served = 2'b01;
    step();
    bus.car_served = '0;
    chk("up1_served", int'(bus.up_pending), 0);
    step();
    chk("up1_req_clear", int'(bus.car_requests), 0);

    // Car0 at 2 going up (cost 5), car1 at 3 going down (cost 2): car1 wins
    set_cars(2, 3, 2'b01, 2'b10);
    bus.hall_dn = 5'b00010;
    push(1, 1, 0);
    step();
    bus.hall_dn = '0;
    chk("dn1_pending", int'(bus.dn_pending), 'b00010);
    wait_sb(12);
    step();
    chk("dn1_request", int'(bus.car_requests), 'h040);
    set_cars(2, 1, 2'b01, 2'b10);
    bus.car_served = 2'b10;
    step();
    bus.car_served = '0;
    chk("dn1_served", int'(bus.dn_pending), 0);
    step();
    chk("dn1_req_clear", int'(bus.car_requests), 0);

    // Invalid buttons: top-floor up and ground-floor down never latch
    bus.hall_up = 5'b10000;
    bus.hall_dn = 5'b00001;
    step();
    bus.hall_up = '0;
    bus.hall_dn = '0;
    chk("inv_up_pending", int'(bus.up_pending), 0);
    chk("inv_dn_pending", int'(bus.dn_pending), 0);
    repeat (12) step();

    // Tie at floor 2: both calls to car0, up0 before dn4
    do_reset();
    set_cars(2, 2, 2'b00, 2'b00);
    bus.hall_up = 5'b00001;
    bus.hall_dn = 5'b10000;
    push(0, 0, 1);
    push(0, 4, 0);
    step();
    bus.hall_up = '0;
    bus.hall_dn = '0;
    wait_sb(14);
    step();
    chk("tie_request", int'(bus.car_requests), 'h011);

    // Reset in the middle of a scan with three pending calls
    do_reset();
    set_cars(2, 2, 2'b00, 2'b00);
    bus.hall_up = 5'b00110;
    bus.hall_dn = 5'b01000;
    push(0, 1, 1);
    step();
    bus.hall_up = '0;
    bus.hall_dn = '0;
    chk("mid_up_pending", int'(bus.up_pending), 'b00110);
    chk("mid_dn_pending", int'(bus.dn_pending), 'b01000);
    step();
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_up", int'(bus.up_pending), 0);
    chk("mid_rst_dn", int'(bus.dn_pending), 0);
    chk("mid_rst_req", int'(bus.car_requests), 0);
    chk("mid_rst_valid", int'(bus.assign_valid), 0);
    reset = 1'b0;
    chk("mid_sb_drained", sb.size(), 0);
    sb.delete();
    repeat (12) step();

    // Service beats a same-cycle re-press; the next press re-latches
    do_reset();
    set_cars(0, 4, 2'b00, 2'b00);
    bus.hall_up = 5'b01000;
    push(1, 3, 1);
    step();
    bus.hall_up = '0;
    wait_sb(12);
    set_cars(0, 3, 2'b00, 2'b00);
    bus.car_served = 2'b10;
    bus.hall_up = 5'b01000;
    step();
    bus.car_served = '0;
    bus.hall_up = '0;
    chk("race_dropped", int'(bus.up_pending), 0);
    bus.hall_up = 5'b01000;
    push(1, 3, 1);
    step();
    bus.hall_up = '0;
    chk("race_relatch", int'(bus.up_pending), 'b01000);
    wait_sb(12);
    step();
    chk("race_request", int'(bus.car_requests), 'h100);

    repeat (3) step();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
